// File: rtl/skid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : skid_pipe_reg
// Brief    : Two-entry valid/ready pipeline stage with a skid register.
//            in_ready is decoded from state only, which breaks the out_ready path.
// Revision : 1.0 - initial release
// ============================================================================
module skid_pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q,  main_d;
    logic [WIDTH-1:0]   skid_q,  skid_d;
    logic               accept;
    logic               drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        accept  = in_valid & in_ready & en;
        drain   = out_valid & out_ready & en;

        // Flush only retires the state; payload registers keep their contents.
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_d  = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = ST_SKID;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != ST_SKID);
        out_valid = (state_q == ST_FULL) || (state_q == ST_SKID);
        out_data  = main_q;
        case (state_q)
            ST_FULL: occupancy = 2'd1;
            ST_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_skid_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_skid_pipe_reg
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skid_pipe_reg;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;

    int checks = 0;
    int errors = 0;

    skid_pipe_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: got v=%b r=%b occ=%0d d=%h, expected v=0 r=1 occ=0 d=00000000",
                     out_valid, in_ready, occupancy, out_data);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got occ=%0d r=%b, expected occ=0 r=1", occupancy, in_ready);
        end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_data = 32'hA5A5A5A5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL basic_latency: got v=%b d=%h occ=%0d, expected v=1 d=a5a5a5a5 occ=1",
                     out_valid, out_data, occupancy);
        end
        tick();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got occ=%0d v=%b, expected occ=0 v=0", occupancy, out_valid);
        end
    endtask

    task automatic test_skid_fill();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h1) begin
            errors++;
            $display("FAIL skid_fill: got occ=%0d r=%b d=%h, expected occ=2 r=0 d=00000001",
                     occupancy, in_ready, out_data);
        end
        in_data = 32'h3;
        tick();
        checks++;
        if (occupancy !== 2'd2 || out_data !== 32'h1) begin
            errors++;
            $display("FAIL skid_stall: got occ=%0d d=%h, expected occ=2 d=00000001", occupancy, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_data !== 32'h2 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL skid_order2: got d=%h occ=%0d, expected d=00000002 occ=1", out_data, occupancy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_data !== 32'h3 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL skid_order3: got d=%h occ=%0d, expected d=00000003 occ=1", out_data, occupancy);
        end
        tick();
        checks++;
        if (occupancy !== 2'd0) begin
            errors++;
            $display("FAIL skid_empty: got occ=%0d, expected occ=0", occupancy);
        end
    endtask

    task automatic test_skid_drain_block();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h11; tick();
        in_data = 32'h12; tick();
        out_ready = 1'b1; in_data = 32'h9;
        tick();
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd1 || out_data !== 32'h12 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid_block: got occ=%0d d=%h r=%b, expected occ=1 d=00000012 r=1",
                     occupancy, out_data, in_ready);
        end
        tick();
        checks++;
        if (occupancy !== 2'd0) begin
            errors++;
            $display("FAIL skid_block_drop: got occ=%0d, expected occ=0", occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h21; tick();
        in_data = 32'h22; tick();
        flush = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h21) begin
            errors++;
            $display("FAIL flush: got occ=%0d v=%b r=%b d=%h, expected occ=0 v=0 r=1 d=00000021",
                     occupancy, out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_enable_hold();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7;
        tick();
        en = 1'b0; in_data = 32'hF; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_data !== 32'h7 || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL en_hold[%0d]: got d=%h occ=%0d, expected d=00000007 occ=1",
                         i, out_data, occupancy);
            end
        end
        en = 1'b1; in_valid = 1'b0;
        tick();
        checks++;
        if (occupancy !== 2'd0) begin
            errors++;
            $display("FAIL en_resume: got occ=%0d, expected occ=0", occupancy);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h31; tick();
        in_data = 32'h32; tick();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b r=%b occ=%0d d=%h, expected v=0 r=1 occ=0 d=00000000",
                     out_valid, in_ready, occupancy, out_data);
        end
        #1 rst = 1'b0;
        in_valid = 1'b1; in_data = 32'h44;
        tick();
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd1 || out_data !== 32'h44) begin
            errors++;
            $display("FAIL post_reset_accept: got occ=%0d d=%h, expected occ=1 d=00000044",
                     occupancy, out_data);
        end
    endtask

    // Reference: a FIFO of accepted words bounded at two entries; out_data
    // shows the most recent head, which persists after the FIFO empties.
    task automatic test_random();
        logic [WIDTH-1:0] mq[$];
        logic [WIDTH-1:0] mhead;
        logic             acc, drn;
        int               exp_occ;

        rst = 1'b1; #2; rst = 1'b0;
        mhead = '0;
        for (int n = 0; n < 400; n++) begin
            en        = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            in_data   = $urandom;
            acc = in_valid && (mq.size() < 2) && en;
            drn = (mq.size() > 0) && out_ready && en;
            if (flush) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
            end
            if (mq.size() > 0) mhead = mq[0];
            tick();
            exp_occ = mq.size();
            checks++;
            if (occupancy !== exp_occ[1:0] || out_valid !== (exp_occ > 0) ||
                in_ready !== (exp_occ < 2) || out_data !== mhead) begin
                errors++;
                $display("FAIL random[%0d]: got occ=%0d v=%b r=%b d=%h, expected occ=%0d v=%b r=%b d=%h",
                         n, occupancy, out_valid, in_ready, out_data,
                         exp_occ, (exp_occ > 0), (exp_occ < 2), mhead);
            end
        end
        flush = 1'b0; en = 1'b1; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skid_fill();
        test_skid_drain_block();
        test_flush();
        test_enable_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion within 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
